// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified-memory arbiter.
//   state_t         - transaction sequencer states IDLE/ISSUE/WAIT/DONE
//   OWN_CPU/OWN_DMA - encoding of the owner / last-grant bit
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/arb2_pick.sv
// arb2_pick: combinational two-way winner select between the CPU and DMA ports.
//   c_req, d_req : pending requests
//   last         : owner of the previous completed transaction
//   valid        : at least one request pending
//   winner       : OWN_CPU or OWN_DMA (meaningful only when valid)
// Build option: ARB_CPU_PRIORITY_EN selects fixed CPU priority (last ignored);
// without it, ties are broken round-robin against last.
module arb2_pick
  import mem_arb_pkg::*;
(
  input  logic c_req,
  input  logic d_req,
  input  logic last,
  output logic valid,
  output logic winner
);

  assign valid = c_req | d_req;

`ifdef ARB_CPU_PRIORITY_EN
  // Fixed priority never looks at the previous owner.
  logic unused_last;
  assign unused_last = last;
  assign winner      = c_req ? OWN_CPU : OWN_DMA;
`else
  always_comb begin
    winner = OWN_CPU;
    if (c_req && d_req) begin
      // Tie: hand the memory to whoever did not have it last.
      winner = ~last;
    end else if (d_req) begin
      winner = OWN_DMA;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory between the CPU
// core and a DMA/program-loader port using req/ack handshakes.
//   clk, reset_n                     : clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata        : CPU request (held until c_ack)
//   c_rdata, c_ack                   : CPU read data (held) and completion pulse
//   d_req/d_we/d_addr/d_wdata        : DMA request, same rules
//   d_rdata, d_ack                   : DMA read data and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata : memory access strobe and registered command
//   mem_rdata                        : memory read data, valid MEM_LAT cycles after mem_en
//   busy                             : high in every state except IDLE
//   owner                            : current or last grant (0 = CPU, 1 = DMA)
// Each transaction runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
// Build option: ARB_CPU_PRIORITY_EN (see arb2_pick) makes the CPU win every tie.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t             state_reg, state_next;
  logic               owner_reg;
  logic               last_reg;
  logic               we_reg;
  logic [AW-1:0]      addr_reg;
  logic [DW-1:0]      wdata_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DW-1:0]      c_rdata_reg;
  logic [DW-1:0]      d_rdata_reg;

  logic               pick_valid;
  logic               pick_winner;
  logic               cnt_last;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;

  arb2_pick u_pick (
    .c_req  (c_req),
    .d_req  (d_req),
    .last   (last_reg),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Command of the port that wins arbitration this cycle.
  assign sel_we    = (pick_winner == OWN_DMA) ? d_we    : c_we;
  assign sel_addr  = (pick_winner == OWN_DMA) ? d_addr  : c_addr;
  assign sel_wdata = (pick_winner == OWN_DMA) ? d_wdata : c_wdata;

  // Final WAIT cycle: this is when mem_rdata is valid.
  assign cnt_last = (cnt_reg == CNT_W'(MEM_LAT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    c_ack      = 1'b0;
    d_ack      = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (pick_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = we_reg;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        c_ack      = (owner_reg == OWN_CPU);
        d_ack      = (owner_reg == OWN_DMA);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_reg   <= OWN_CPU;
      last_reg    <= OWN_DMA;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      cnt_reg     <= '0;
      c_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Latch the whole command so later input changes cannot leak in.
          if (pick_valid) begin
            owner_reg <= pick_winner;
            we_reg    <= sel_we;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
          end
        end
        ISSUE: begin
          cnt_reg <= '0;
        end
        WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_last && !we_reg) begin
            if (owner_reg == OWN_DMA) begin
              d_rdata_reg <= mem_rdata;
            end else begin
              c_rdata_reg <= mem_rdata;
            end
          end
        end
        DONE: begin
          last_reg <= owner_reg;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign c_rdata   = c_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus against a transaction-timeline model of
// the arbiter, plus hand-computed latency/data expectations per scenario.
// A second instance with MEM_LAT=3 covers the longer-latency timing.
module tb_mem_arbiter;

  localparam int LAT = 1;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
  } en_ev_t;

  typedef struct {
    int   cyc;
    logic port;
  } ack_ev_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        c_ack, d_ack, mem_en, mem_we, busy, owner;

  logic        l3_c_req = 1'b0;
  logic [31:0] l3_c_addr = '0;
  logic [31:0] l3_c_rdata, l3_d_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;
  logic        l3_c_ack, l3_d_ack, l3_mem_en, l3_mem_we, l3_busy, l3_owner;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          cyc = 0;

  en_ev_t  mlog[$];
  ack_ev_t alog[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n),
    .c_req(l3_c_req), .c_we(1'b0), .c_addr(l3_c_addr), .c_wdata(32'h0),
    .c_rdata(l3_c_rdata), .c_ack(l3_c_ack),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
    .d_rdata(l3_d_rdata), .d_ack(l3_d_ack),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata),
    .busy(l3_busy), .owner(l3_owner)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'h1111_1111;
      1:       return 32'h2222_2222;
      2:       return 32'h3333_3333;
      4:       return 32'hDEAD_BEEF;
      12:      return 32'hCAFE_F00D;
      default: return 32'hA500_0000 | 32'(i);
    endcase
  endfunction

  // Memory with LAT (main) and 3 (second instance) cycles of read latency.
  // Junk is shifted in on idle cycles so a mistimed capture shows up.
  logic [31:0] mem [256];
  logic [31:0] rd1 [LAT];
  logic [31:0] rd3 [3];
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    rd1[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rd1[i] <= rd1[i-1];
    rd3[0] <= l3_mem_en ? mem[l3_mem_addr[9:2]] : 32'hBAD3_BAD3;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  assign mem_rdata    = rd1[LAT-1];
  assign l3_mem_rdata = rd3[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Model: a granted transaction started at cycle t0 has mem_en at t0+1,
  // busy for t0+1..t0+LAT+2 and its ack (and read data) at t0+LAT+2.
  logic [31:0] model_mem [256];
  bit          m_init = 1'b0;
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  logic        m_own = 1'b0, m_we = 1'b0, m_last = 1'b1, m_owner = 1'b0;
  logic [31:0] m_maddr = '0, m_mwdata = '0, m_c_rdata = '0, m_d_rdata = '0;

  initial begin : compare
    int   off;
    logic e_en, e_done, pick;
    forever begin
      @(negedge clk);
      if (!m_init) begin
        for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
        m_init = 1'b1;
      end
      if (!reset_n) begin
        m_active = 1'b0; m_last = 1'b1; m_owner = 1'b0;
        m_maddr = '0; m_mwdata = '0; m_c_rdata = '0; m_d_rdata = '0;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_acks", 32'({c_ack, d_ack}), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_c_rdata", c_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
      end else begin
        off    = m_active ? (cyc - m_t0) : 0;
        e_en   = m_active && (off == 1);
        e_done = m_active && (off == LAT + 2);
        if (e_en && m_we) model_mem[m_maddr[9:2]] = m_mwdata;
        if (e_done && !m_we) begin
          if (m_own) m_d_rdata = model_mem[m_maddr[9:2]];
          else       m_c_rdata = model_mem[m_maddr[9:2]];
        end
        chk("busy", 32'(busy), 32'(m_active));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_en && m_we));
        chk("c_ack", 32'(c_ack), 32'(e_done && !m_own));
        chk("d_ack", 32'(d_ack), 32'(e_done && m_own));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("mem_addr", mem_addr, m_maddr);
        chk("mem_wdata", mem_wdata, m_mwdata);
        chk("c_rdata", c_rdata, m_c_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        if (mem_en) mlog.push_back('{cyc, mem_addr, mem_we});
        if (c_ack)  alog.push_back('{cyc, 1'b0});
        if (d_ack)  alog.push_back('{cyc, 1'b1});
        if (e_done) begin
          m_last   = m_own;
          m_active = 1'b0;
        end else if (!m_active && (c_req || d_req)) begin
`ifdef ARB_CPU_PRIORITY_EN
          pick = !c_req;
`else
          pick = (c_req && d_req) ? !m_last : !c_req;
`endif
          m_active = 1'b1;
          m_t0     = cyc;
          m_own    = pick;
          m_owner  = pick;
          m_we     = pick ? d_we    : c_we;
          m_maddr  = pick ? d_addr  : c_addr;
          m_mwdata = pick ? d_wdata : c_wdata;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an ack on a port, then step past the ack edge.
  task automatic wait_ack(input logic port, output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((port ? d_ack : c_ack) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL ack_timeout port=%0d actual=none required=ack within 40 cycles", port);
    end
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0, at, a0, a1, a2, nd, n;
    logic exp_port [4];

    // Reset state.
    repeat (3) tick();
    chk("t0_reset_busy", 32'(busy), 32'h0);
    chk("t0_reset_owner", 32'(owner), 32'h0);
    reset_n = 1'b1;
    tick();

    // 1: CPU read of 0x10.
    mlog.delete(); alog.delete();
    t0 = cyc; c_we = 1'b0; c_addr = 32'h10; c_req = 1'b1;
    wait_ack(1'b0, at); c_req = 1'b0;
    chk("t1_ack_latency", at - t0, 32'd3);
    chk("t1_c_rdata", c_rdata, 32'hDEAD_BEEF);
    chk("t1_en_count", mlog.size(), 32'd1);
    chk("t1_en_cycle", mlog[0].cyc - t0, 32'd1);
    chk("t1_en_addr", mlog[0].addr, 32'h10);
    chk("t1_en_we", 32'(mlog[0].we), 32'h0);
    nd = 0;
    foreach (alog[i]) if (alog[i].port) nd++;
    chk("t1_no_d_ack", nd, 32'd0);
    $display("txn t1 cpu rd 0x10 ack@+%0d rdata=%h", at - t0, c_rdata);

    // 2: DMA write then CPU read-back.
    mlog.delete();
    t0 = cyc; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; d_req = 1'b1;
    wait_ack(1'b1, at); d_req = 1'b0;
    chk("t2_d_ack_latency", at - t0, 32'd3);
    chk("t2_issue_we", 32'(mlog[0].we), 32'h1);
    chk("t2_d_rdata_kept", d_rdata, 32'h0);
    $display("txn t2 dma wr 0x20 ack@+%0d", at - t0);
    t0 = cyc; c_we = 1'b0; c_addr = 32'h20; c_req = 1'b1;
    wait_ack(1'b0, at); c_req = 1'b0;
    chk("t2_c_readback", c_rdata, 32'h1234_5678);
    chk("t2_c_ack_latency", at - t0, 32'd3);
    $display("txn t2 cpu rd 0x20 ack@+%0d rdata=%h", at - t0, c_rdata);

    // 3: both ports requesting continuously from reset.
    reset_n = 1'b0; d_we = 1'b0;
    tick(); tick();
    alog.delete();
    reset_n = 1'b1;
    c_addr = 32'h40; d_addr = 32'h44; c_req = 1'b1; d_req = 1'b1;
    t0 = cyc;
    n = 0;
    while (alog.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tick();
    c_req = 1'b0; d_req = 1'b0;
    chk("t3_ack_count", alog.size(), 32'd4);
`ifdef ARB_CPU_PRIORITY_EN
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_ack%0d_cycle", i), alog[i].cyc - t0, 32'(3 + 4 * i));
      chk($sformatf("t3_ack%0d_port", i), 32'(alog[i].port), 32'(exp_port[i]));
      $display("txn t3 grant%0d port=%0d ack@+%0d", i, alog[i].port, alog[i].cyc - t0);
    end
    tick();

    // 5: reset during WAIT aborts the transaction.
    t0 = cyc; c_we = 1'b0; c_addr = 32'h10; c_req = 1'b1;
    tick(); tick();
    reset_n = 1'b0; c_req = 1'b0;
    #1;
    chk("t5_abort_busy", 32'(busy), 32'h0);
    chk("t5_abort_mem_en", 32'(mem_en), 32'h0);
    chk("t5_abort_acks", 32'({c_ack, d_ack}), 32'h0);
    tick(); tick();
    chk("t5_c_rdata_cleared", c_rdata, 32'h0);
    reset_n = 1'b1;
    alog.delete(); mlog.delete();
    repeat (6) tick();
    chk("t5_no_ack_after", alog.size(), 32'd0);
    chk("t5_no_en_after", mlog.size(), 32'd0);
    t0 = cyc; c_req = 1'b1;
    wait_ack(1'b0, at); c_req = 1'b0;
    chk("t5_resume_latency", at - t0, 32'd3);
    chk("t5_resume_rdata", c_rdata, 32'hDEAD_BEEF);
    $display("txn t5 abort then cpu rd 0x10 ack@+%0d rdata=%h", at - t0, c_rdata);

    // 6: CPU keeps req high and advances the address on every ack.
    mlog.delete();
    t0 = cyc; c_addr = 32'h0; c_req = 1'b1;
    wait_ack(1'b0, a0); c_addr = 32'h4;
    wait_ack(1'b0, a1); c_addr = 32'h8;
    wait_ack(1'b0, a2); c_req = 1'b0;
    chk("t6_ack0", a0 - t0, 32'd3);
    chk("t6_ack1", a1 - t0, 32'd7);
    chk("t6_ack2", a2 - t0, 32'd11);
    chk("t6_en_count", mlog.size(), 32'd3);
    chk("t6_addr0", mlog[0].addr, 32'h0);
    chk("t6_addr1", mlog[1].addr, 32'h4);
    chk("t6_addr2", mlog[2].addr, 32'h8);
    chk("t6_last_rdata", c_rdata, 32'h3333_3333);
    $display("txn t6 cpu rd 0x0/0x4/0x8 acks@+%0d/+%0d/+%0d", a0 - t0, a1 - t0, a2 - t0);

    // 4: MEM_LAT=3 instance, CPU read of 0x30.
    t0 = cyc; l3_c_addr = 32'h30; l3_c_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t4_mem_en_k%0d", k), 32'(l3_mem_en), 32'(k == 1));
      chk($sformatf("t4_busy_k%0d", k), 32'(l3_busy), 32'(k >= 1 && k <= 5));
      chk($sformatf("t4_c_ack_k%0d", k), 32'(l3_c_ack), 32'(k == 5));
      if (k == 1) chk("t4_mem_addr", l3_mem_addr, 32'h30);
      if (k == 5) begin
        chk("t4_c_rdata", l3_c_rdata, 32'hCAFE_F00D);
        l3_c_req = 1'b0;
      end
    end
    $display("txn t4 lat3 cpu rd 0x30 rdata=%h", l3_c_rdata);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single unified instruction/data memory of the multicycle MIPS between two requesters: the CPU core (fetch, lw, sw) and a DMA/program-loader port. Each requester uses a req/ack handshake. The arbiter grants one requester per transaction and sequences the memory access with a fixed, parameterised read latency. It sits between the core/loader and the memory; the core's controller stalls in its memory states until c_ack.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, cycles from the mem_en issue cycle to valid mem_rdata; must be >= 1

Ports:
clk  in  1  clock, all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
c_req  in  1  CPU request; held until c_ack
c_we  in  1  CPU write enable (1 = store)
c_addr  in  AW  CPU byte address
c_wdata  in  DW  CPU store data
c_rdata  out  DW  CPU read data; valid in the c_ack cycle and held afterwards
c_ack  out  1  one-cycle completion pulse to the CPU
d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  DMA request signals, same rules as the CPU port
d_rdata  out  DW  DMA read data
d_ack  out  1  DMA completion pulse
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address, registered
mem_wdata  out  DW  memory write data, registered
mem_rdata  in  DW  memory read data
busy  out  1  high whenever state != IDLE
owner  out  1  current or last grant (0 = CPU, 1 = DMA)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; last=DMA, so the CPU wins the first tie; owner=0. All other outputs (c_rdata, d_rdata, acks, mem_*, busy) = 0.
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: sample c_req/d_req.
  - One request: grant it.
  - Both requests: grant !last (round-robin).
  - Register owner, we, addr and wdata into the mem_* registers; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_en=1 for exactly this cycle, mem_we=registered we; clear the latency counter; go to WAIT.
- WAIT: lasts exactly MEM_LAT cycles. The counter increments each cycle, width $clog2(MEM_LAT+1). On the cycle with cnt==MEM_LAT-1:
  - a read captures mem_rdata into the owner's rdata register;
  - go to DONE.
- DONE: the owner's ack=1 for exactly this cycle; last<=owner; go to IDLE.
- Latency: with the request seen in IDLE at cycle T0, ack occurs at T0+MEM_LAT+2, and the same for writes. A transaction occupies MEM_LAT+3 cycles including IDLE.
- Handshake:
  - Requesters hold req/we/addr/wdata stable until ack.
  - A req still high in the IDLE cycle after DONE is a new transaction; requesters must update addr on the ack edge.
  - Changing inputs mid-transaction has no effect, because everything is latched in IDLE.
- No preemption: a granted transaction always completes. A request from the other port waits in IDLE arbitration.
- rdata of a port changes only on that port's reads. Writes leave it untouched.
- mem_en, c_ack and d_ack are never high simultaneously with each other's port. c_ack and d_ack are never both 1.
- Reset mid-transaction: immediate abort with no ack and no further mem_en. After release the FSM starts from IDLE.

Optional Feature:
ARB_CPU_PRIORITY_EN:
- Defined: fixed priority; the CPU wins every tie and last is ignored. DMA can be starved while c_req is held.
- Undefined: round-robin as described above.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT, DONE) and owner constants OWN_CPU=0, OWN_DMA=1.
- One natural sub-module, arb2_pick: a combinational 2-way winner select from c_req, d_req and last, containing the ARB_CPU_PRIORITY_EN switch.

Test Plan:
1. MEM_LAT=1, mem[0x10]=0xDEADBEEF, CPU read 0x10 at T0 -> mem_en=1, mem_we=0, mem_addr=0x10 at T1 only; c_ack pulse at T3 with c_rdata=0xDEADBEEF; d_ack stays 0.
2. DMA write 0x20<=0x12345678, then CPU read 0x20 -> mem_we=1 in ISSUE, d_ack at T3; CPU read returns 0x12345678; d_rdata unchanged (0).
3. Both req held continuously from reset -> grants CPU, DMA, CPU, DMA; acks at T3, T7, T11, T15. With ARB_CPU_PRIORITY_EN -> only c_ack every 4 cycles and d_ack never.
4. MEM_LAT=3, CPU read -> mem_en at T1, c_ack at T5; busy high T1..T5.
5. reset_n low during WAIT -> busy, mem_en and acks 0 immediately; no ack after release; c_rdata=0; next request completes normally.
6. CPU holds c_req, changing addr on each ack (0x0, 0x4, 0x8) -> c_ack every 4 cycles; mem_addr sequence 0x0, 0x4, 0x8.
